// File: rtl/pipelined_muldiv_alu.sv
// rtl/pipelined_muldiv_alu.sv - RV32I ALU/branch plus iterative RV32M mul/div with valid/ready handshake
module pipelined_muldiv_alu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              branch_op,
  input  logic [5:0]        alu_control,
  input  logic [XLEN-1:0]   operand_a,
  input  logic [XLEN-1:0]   operand_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              branch,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [SHAMT_W-1:0] LP_CNT_INIT = SHAMT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]    LP_MIN      = {1'b1, {(XLEN-1){1'b0}}};

  state_t              r_state, w_state_next;
  logic [SHAMT_W-1:0]  r_count;
  logic [2*XLEN-1:0]   r_p;
  logic [XLEN-1:0]     r_b;
  logic                r_neg;
  logic                r_isdiv;
  logic [1:0]          r_op;
  logic [XLEN-1:0]     r_result;
  logic                r_branch;

  logic [SHAMT_W-1:0]  w_shamt;
  logic [XLEN-1:0]     w_alu_res;
  logic                w_cmp, w_is_br;
  logic                w_is_iter, w_is_div, w_sa, w_sb, w_a_neg, w_b_neg, w_neg;
  logic [XLEN-1:0]     w_a_mag, w_b_mag;
  logic                w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0]     w_special_res;
  logic                w_accept;
  logic [XLEN:0]       w_mul_sum, w_rsh;
  logic [XLEN-1:0]     w_rdiff;
  logic                w_ge;
  logic [2*XLEN-1:0]   w_p_next, w_prod_fix;
  logic [XLEN-1:0]     w_q_fix, w_r_fix, w_iter_res;

  // Single-cycle ALU, compare and branch evaluation
  always_comb begin
    w_alu_res = '0;
    w_cmp     = 1'b0;
    w_is_br   = 1'b0;
    w_shamt   = operand_b[SHAMT_W-1:0];
    case (alu_control)
      6'b000000: w_alu_res = operand_a + operand_b;
      6'b001000: w_alu_res = operand_a - operand_b;
      6'b000001: w_alu_res = operand_a << w_shamt;
      6'b000101: w_alu_res = operand_a >> w_shamt;
      6'b001101: w_alu_res = $unsigned($signed(operand_a) >>> w_shamt);
      6'b000010: begin w_cmp = $signed(operand_a) < $signed(operand_b); w_alu_res = {{(XLEN-1){1'b0}}, w_cmp}; end
      6'b000011: begin w_cmp = operand_a < operand_b; w_alu_res = {{(XLEN-1){1'b0}}, w_cmp}; end
      6'b000100: w_alu_res = operand_a ^ operand_b;
      6'b000110: w_alu_res = operand_a | operand_b;
      6'b000111: w_alu_res = operand_a & operand_b;
      6'b011111, 6'b111111: w_alu_res = operand_a;
      6'b010000: begin w_is_br = 1'b1; w_cmp = operand_a == operand_b; w_alu_res = {{(XLEN-1){1'b0}}, w_cmp}; end
      6'b010001: begin w_is_br = 1'b1; w_cmp = operand_a != operand_b; w_alu_res = {{(XLEN-1){1'b0}}, w_cmp}; end
      6'b010100: begin w_is_br = 1'b1; w_cmp = $signed(operand_a) < $signed(operand_b); w_alu_res = {{(XLEN-1){1'b0}}, w_cmp}; end
      6'b010101: begin w_is_br = 1'b1; w_cmp = $signed(operand_a) >= $signed(operand_b); w_alu_res = {{(XLEN-1){1'b0}}, w_cmp}; end
      6'b010110: begin w_is_br = 1'b1; w_cmp = operand_a < operand_b; w_alu_res = {{(XLEN-1){1'b0}}, w_cmp}; end
      6'b010111: begin w_is_br = 1'b1; w_cmp = operand_a >= operand_b; w_alu_res = {{(XLEN-1){1'b0}}, w_cmp}; end
      default:   w_alu_res = '0;
    endcase
  end

  // Operand magnitudes, sign correction flag and division special cases
  always_comb begin
    w_is_iter  = alu_control[5:3] == 3'b100;
    w_is_div   = alu_control[2];
    w_sa       = w_is_div ? ~alu_control[0] : (alu_control[1:0] == 2'b01 || alu_control[1:0] == 2'b10);
    w_sb       = w_is_div ? ~alu_control[0] : (alu_control[1:0] == 2'b01);
    w_a_neg    = w_sa & operand_a[XLEN-1];
    w_b_neg    = w_sb & operand_b[XLEN-1];
    w_a_mag    = w_a_neg ? -operand_a : operand_a;
    w_b_mag    = w_b_neg ? -operand_b : operand_b;
    // remainder follows the dividend's sign; quotient and products follow the xor
    w_neg      = (w_is_div && alu_control[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = operand_b == '0;
    w_div_ovf  = ~alu_control[0] && operand_a == LP_MIN && operand_b == '1;
    w_special  = w_is_iter & w_is_div & (w_div_zero | w_div_ovf);
    if (w_div_zero) w_special_res = alu_control[1] ? operand_a : '1;
    else            w_special_res = alu_control[1] ? '0 : operand_a;
    w_accept   = in_valid & (r_state == IDLE) & ~flush;
  end

  // One shift-add or restoring-divide step; r_p holds {hi, lo} for both
  always_comb begin
    w_mul_sum  = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_b} : '0);
    w_rsh      = r_p[2*XLEN-1:XLEN-1];
    w_ge       = w_rsh >= {1'b0, r_b};
    w_rdiff    = w_rsh[XLEN-1:0] - r_b;
    if (r_isdiv) w_p_next = {(w_ge ? w_rdiff : w_rsh[XLEN-1:0]), r_p[XLEN-2:0], w_ge};
    else         w_p_next = {w_mul_sum, r_p[XLEN-1:1]};
    w_prod_fix = r_neg ? -w_p_next : w_p_next;
    w_q_fix    = r_neg ? -w_p_next[XLEN-1:0] : w_p_next[XLEN-1:0];
    w_r_fix    = r_neg ? -w_p_next[2*XLEN-1:XLEN] : w_p_next[2*XLEN-1:XLEN];
    if (r_isdiv)            w_iter_res = r_op[1] ? w_r_fix : w_q_fix;
    else if (r_op == 2'b00) w_iter_res = w_prod_fix[XLEN-1:0];
    else                    w_iter_res = w_prod_fix[2*XLEN-1:XLEN];
  end

  // FSM next state and handshake outputs; flush overrides everything
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = (w_is_iter && !w_special) ? BUSY : DONE;
      BUSY:    if (r_count == '0) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (flush) w_state_next = IDLE;
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    busy      = r_state == BUSY;
    result    = r_result;
    branch    = r_branch;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath: capture on accept, iterate while BUSY, latch final result on the last step
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_p      <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_isdiv  <= 1'b0;
      r_op     <= 2'b00;
      r_result <= '0;
      r_branch <= 1'b0;
    end else if (w_accept) begin
      r_count  <= LP_CNT_INIT;
      r_p      <= {{XLEN{1'b0}}, w_a_mag};
      r_b      <= w_b_mag;
      r_neg    <= w_neg;
      r_isdiv  <= w_is_div;
      r_op     <= alu_control[1:0];
      r_result <= w_special ? w_special_res : w_alu_res;
      r_branch <= branch_op & w_is_br & w_cmp;
    end else if (r_state == BUSY && !flush) begin
      r_p <= w_p_next;
      if (r_count == '0) r_result <= w_iter_res;
      else               r_count  <= r_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_pipelined_muldiv_alu.sv
// tb/tb_pipelined_muldiv_alu.sv - table-driven scoreboard bench for pipelined_muldiv_alu
module tb_pipelined_muldiv_alu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        branch_op = 1'b0;
  logic        out_ready = 1'b1;
  logic [5:0]  alu_control = 6'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        in_ready, out_valid, branch, busy;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        bop;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        br;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  pipelined_muldiv_alu #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .branch_op(branch_op), .alu_control(alu_control),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .branch(branch), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic bop, input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic br, input int lat);
    vec_t v;
    v.bop = bop; v.op = op; v.a = a; v.b = b; v.res = res; v.br = br; v.lat = lat;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.res = v.res;
    e.br  = v.br;
    sb_q.push_back(e);
  endtask

  task automatic issue(input vec_t v);
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; branch_op = v.bop; alu_control = v.op; operand_a = v.a; operand_b = v.b;
    tick();
    in_valid = 1'b0;
    branch_op = 1'($urandom);
    alu_control = 6'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic wait_out(output int lat, output int bcnt);
    lat = 1;
    bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic compare_out(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard actual=empty required=entry", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_result"}, result, e.res);
      chk({name, "_branch"}, {31'd0, branch}, {31'd0, e.br});
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat, bcnt;
    push_exp(v);
    issue(v);
    wait_out(lat, bcnt);
    chk({name, "_latency"}, lat, v.lat);
    chk({name, "_busy_cycles"}, bcnt, v.lat - 1);
    compare_out(name);
    tick();
    chk({name, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int   lat, bcnt;
    logic seen;

    vecs.push_back(mk(0, 6'b000000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1));
    vecs.push_back(mk(0, 6'b001000, 32'd5,        32'd7,        32'hFFFFFFFE, 0, 1));
    vecs.push_back(mk(0, 6'b000001, 32'h1,        32'h24,       32'h10,       0, 1));
    vecs.push_back(mk(0, 6'b000101, 32'h80000000, 32'h1F,       32'h1,        0, 1));
    vecs.push_back(mk(0, 6'b001101, 32'h80000000, 32'h21,       32'hC0000000, 0, 1));
    vecs.push_back(mk(0, 6'b000010, 32'hFFFFFFFF, 32'h1,        32'h1,        0, 1));
    vecs.push_back(mk(0, 6'b000011, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 1));
    vecs.push_back(mk(0, 6'b000100, 32'hF0F0,     32'h0FF0,     32'hFF00,     0, 1));
    vecs.push_back(mk(0, 6'b000110, 32'hF0F0,     32'h0FF0,     32'hFFF0,     0, 1));
    vecs.push_back(mk(0, 6'b000111, 32'hF0F0,     32'h0FF0,     32'h00F0,     0, 1));
    vecs.push_back(mk(0, 6'b011111, 32'h1234,     32'h99,       32'h1234,     0, 1));
    vecs.push_back(mk(0, 6'b111111, 32'hABCD,     32'h99,       32'hABCD,     0, 1));
    vecs.push_back(mk(1, 6'b010000, 32'd5,        32'd5,        32'h1,        1, 1));
    vecs.push_back(mk(1, 6'b010001, 32'd5,        32'd5,        32'h0,        0, 1));
    vecs.push_back(mk(1, 6'b010110, 32'h1,        32'hFFFFFFFF, 32'h1,        1, 1));
    vecs.push_back(mk(0, 6'b010100, 32'hFFFFFFFF, 32'h1,        32'h1,        0, 1));
    vecs.push_back(mk(1, 6'b010101, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 1));
    vecs.push_back(mk(1, 6'b010111, 32'hFFFFFFFF, 32'h1,        32'h1,        1, 1));
    vecs.push_back(mk(1, 6'b101000, 32'h5,        32'h5,        32'h0,        0, 1));
    vecs.push_back(mk(0, 6'b100001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 33));
    vecs.push_back(mk(0, 6'b100011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33));
    vecs.push_back(mk(0, 6'b100000, 32'd6,        32'd7,        32'd42,       0, 33));
    vecs.push_back(mk(0, 6'b100010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33));
    vecs.push_back(mk(0, 6'b100000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 0, 33));
    vecs.push_back(mk(0, 6'b100100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1));
    vecs.push_back(mk(0, 6'b100110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 1));
    vecs.push_back(mk(0, 6'b100101, 32'd7,        32'd0,        32'hFFFFFFFF, 0, 1));
    vecs.push_back(mk(0, 6'b100111, 32'd7,        32'd0,        32'd7,        0, 1));
    vecs.push_back(mk(0, 6'b100100, 32'd7,        32'd0,        32'hFFFFFFFF, 0, 1));
    vecs.push_back(mk(0, 6'b100100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 33));
    vecs.push_back(mk(0, 6'b100110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 33));
    vecs.push_back(mk(0, 6'b100110, 32'd7,        32'hFFFFFFFE, 32'h1,        0, 33));
    vecs.push_back(mk(0, 6'b100101, 32'd100,      32'd7,        32'd14,       0, 33));
    vecs.push_back(mk(0, 6'b100111, 32'd100,      32'd7,        32'd2,        0, 33));
    vecs.push_back(mk(0, 6'b100101, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 0, 33));
    vecs.push_back(mk(0, 6'b100111, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 0, 33));

    // reset state
    tick(); tick();
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy",      {31'd0, busy},      32'd0);
    chk("reset_result",    result,             32'd0);
    chk("reset_branch",    {31'd0, branch},    32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d_op%b", i, vecs[i].op));
    end

    // back-pressure: DONE holds with out_ready low
    out_ready = 1'b0;
    push_exp(mk(0, 6'b100000, 32'd6, 32'd7, 32'd42, 0, 33));
    issue(mk(0, 6'b100000, 32'd6, 32'd7, 32'd42, 0, 33));
    wait_out(lat, bcnt);
    chk("bp_latency", lat, 33);
    compare_out("bp_first");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_result",    result,             32'd42);
      chk("bp_hold_in_ready",  {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

    // flush at BUSY cycle 10 drops the op
    issue(mk(0, 6'b100101, 32'd100, 32'd7, 32'd14, 0, 33));
    for (int i = 0; i < 9; i++) tick();
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    chk("flush_busy",      {31'd0, busy},      32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_late_out_valid", {31'd0, seen}, 32'd0);

    // flush wins over a simultaneous accept
    flush = 1'b1; in_valid = 1'b1; alu_control = 6'b000000; operand_a = 32'd1; operand_b = 32'd2;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_accept_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_accept_in_ready",  {31'd0, in_ready},  32'd1);

    // asynchronous reset mid-DIV
    issue(mk(0, 6'b100100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, 33));
    for (int i = 0; i < 5; i++) tick();
    chk("areset_busy_before", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("areset_busy",      {31'd0, busy},      32'd0);
    chk("areset_result",    result,             32'd0);
    chk("areset_branch",    {31'd0, branch},    32'd0);
    reset = 1'b0;
    tick();
    run_vec(mk(0, 6'b000000, 32'd40, 32'd2, 32'd42, 0, 1), "post_reset_add");

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_muldiv_alu.md
# pipelined_muldiv_alu

Parametrised, handshaked successor to the core's single-cycle ALU. It executes the full RV32I ALU/branch operation set in one cycle and adds the RV32M multiply/divide/remainder operations via an iterative shift-add / restoring-divide datapath. It sits in the EX stage between ID/EX and EX/MEM and stalls the pipeline through a valid/ready handshake while a multi-cycle operation is in flight.

## Interface
- XLEN, 32: operand/result width; must be a power of two, ≥ 8.
- SHAMT_W, $clog2(XLEN): shift-amount bits taken from operand_b.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; drops any in-flight op.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- branch_op  in  1  request is a conditional branch.
- alu_control  in  6  operation code.
- operand_a  in  XLEN  first operand.
- operand_b  in  XLEN  second operand.
- out_valid  out  1  result/branch valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  registered result.
- branch  out  1  registered branch-taken flag.
- busy  out  1  high in BUSY state.

## Operation
- Single-cycle codes, same encodings as the existing ALU:
  - 000000 ADD; 001000 SUB.
  - 000001 SLL; 000101 SRL; 001101 SRA (arithmetic).
  - 000010 SLT signed; 000011 SLTU.
  - 000100 XOR; 000110 OR; 000111 AND.
  - 011111 / 111111 JAL/JALR pass operand_a.
  - 010000 BEQ; 010001 BNE; 010100 BLT; 010101 BGE; 010110 BLTU; 010111 BGEU.
- Shifts use only operand_b[SHAMT_W-1:0].
- Compare and branch results are zero-extended to XLEN.
- branch = compare result when branch_op=1 and the code is a branch code; otherwise 0. BEQ and BNE are distinct: 010000 is taken iff A==B, 010001 is taken iff A!=B.
- Iterative codes:
  - 100000 MUL: low XLEN bits.
  - 100001 MULH: signed×signed, high half.
  - 100010 MULHSU: signed A × unsigned B, high half.
  - 100011 MULHU: high half.
  - 100100 DIV; 100101 DIVU; 100110 REM; 100111 REMU.
- Signed mul/div: convert operands to magnitudes, iterate unsigned, then apply sign correction. MUL uses a 2·XLEN-bit product register.
- Division special cases resolve in the accept cycle, skipping BUSY:
  - Divide by zero: quotient = all-ones; remainder = dividend.
  - Signed overflow (A = −2^(XLEN−1), B = −1): quotient = A; remainder = 0.
- Unknown code: result 0, branch 0, single-cycle.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_valid && in_ready. A single-cycle or special-case op goes to DONE. A mul/div op goes to BUSY and loads count = XLEN−1.
  - BUSY: one iteration per cycle. At count = 0, goes to DONE; otherwise count decrements.
  - DONE: out_valid = 1. If out_ready, goes to IDLE.
- result and branch are held stable in DONE until the handshake.
- flush in any state: next state IDLE, out_valid = 0, result discarded. flush takes priority over a simultaneous accept or out_ready.

## Timing
- Reset values: state IDLE; in_ready 1; out_valid 0; busy 0; result 0; branch 0; counter 0.
- Single-cycle op: accepted at edge N, out_valid at edge N+1.
- Mul/div op: accepted at edge N; busy from N+1 through N+XLEN; out_valid at N+XLEN+1. XLEN=32 gives 33 cycles of latency.
- out_ready held high: DONE→IDLE takes one cycle. in_ready reasserts the cycle after the handshake, so there is no same-cycle back-to-back accept. Maximum throughput is one op per 2 cycles.
- out_ready low: DONE persists indefinitely with outputs stable.
- Inputs are sampled only in the accept cycle. Operand changes afterwards have no effect.
- Reset asserted mid-BUSY: state returns immediately (asynchronously) to reset values.

## Test plan
- ADD 0x7FFFFFFF + 1 -> result 0x80000000, out_valid one cycle after accept. SRA 0x80000000 by B=0x21 (shamt 1) -> 0xC0000000.
- BEQ with branch_op=1, A=B=5 -> branch 1; BNE with same operands -> branch 0; BLTU A=1, B=0xFFFFFFFF -> branch 1; branch_op=0 with BLT code -> branch 0.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MUL 6 × 7 -> 42. Each: busy for exactly 32 cycles, out_valid on the 33rd.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both in 1 cycle. DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7. DIV −7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
- out_ready held low 10 cycles after a MUL completes -> out_valid and result stable, in_ready 0; raise out_ready -> in_ready 1 the following cycle.
- flush at BUSY cycle 10 -> IDLE next cycle, no out_valid. Async reset mid-DIV -> all outputs at reset values before the next edge. A subsequent ADD completes normally.
